// File: rtl/wb_output_arbiter_pkg.sv
// Shared definitions for the writeback output arbiter: source encodings
// (shared with the control decoder) and the output-slot FSM states.
package wb_output_arbiter_pkg;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_ALU  = 2'b01;
  localparam logic [1:0] SRC_MEM  = 2'b10;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/wb_starve_ctr.sv
// Saturating count of consecutive arbitration losses by a waiting ALU request.
// Counts up to LIMIT and holds there until cleared.
module wb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_inc,
  input  logic       i_clr,
  output logic [3:0] o_cnt,
  output logic       o_at_limit
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_inc && (r_cnt < LIM)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_at_limit = (r_cnt >= LIM);

endmodule

// File: rtl/wb_output_arbiter.sv
// Arbitrates ALU results and load data onto the single writeback port through
// a one-beat registered slot; memory wins ties unless the ALU has starved.
module wb_output_arbiter
  import wb_output_arbiter_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [REG_AW-1:0] mem_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_AW-1:0] out_rd,
  output logic [1:0]        out_src,
  output logic [3:0]        starve_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; ready here is combinational from valid, slot state, out_ready and
  // the starvation count, and never depends on ready being seen first.

  slot_state_e       r_state;
  slot_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [REG_AW-1:0] r_rd;
  logic [1:0]        r_src;

  logic w_slot_free;
  logic w_alu_req;
  logic w_mem_req;
  logic w_alu_drop;
  logic w_mem_drop;
  logic w_grant_alu;
  logic w_grant_mem;
  logic w_at_limit;
  logic w_starve_inc;
  logic w_starve_clr;

  wb_starve_ctr #(
    .LIMIT(STARVE_MAX)
  ) u_starve_ctr (
    .clk        (clk),
    .reset      (reset),
    .i_inc      (w_starve_inc),
    .i_clr      (w_starve_clr),
    .o_cnt      (starve_cnt),
    .o_at_limit (w_at_limit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_alu_drop   = alu_valid && (alu_rd == '0);
    w_mem_drop   = mem_valid && (mem_rd == '0);
    w_alu_req    = alu_valid && (alu_rd != '0);
    w_mem_req    = mem_valid && (mem_rd != '0);
    w_slot_free  = (r_state == ST_EMPTY) || out_ready;
    w_grant_alu  = 1'b0;
    w_grant_mem  = 1'b0;
    w_state_nxt  = r_state;

    if (!reset && w_slot_free) begin
      if (w_alu_req && w_mem_req) begin
        w_grant_alu = w_at_limit;
        w_grant_mem = !w_at_limit;
      end else begin
        w_grant_alu = w_alu_req;
        w_grant_mem = w_mem_req;
      end
    end

    // Writes to x0 are swallowed without ever occupying the slot.
    alu_ready    = !reset && (w_alu_drop || w_grant_alu);
    mem_ready    = !reset && (w_mem_drop || w_grant_mem);
    w_starve_clr = w_alu_drop || w_grant_alu;
    w_starve_inc = w_grant_mem && w_alu_req;

    if (w_grant_alu || w_grant_mem) begin
      w_state_nxt = ST_FULL;
    end else if ((r_state == ST_FULL) && out_ready) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // Payload registers keep the last beat while EMPTY; only reset zeroes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_rd   <= '0;
      r_src  <= SRC_NONE;
    end else if (w_grant_alu) begin
      r_data <= alu_data;
      r_rd   <= alu_rd;
      r_src  <= SRC_ALU;
    end else if (w_grant_mem) begin
      r_data <= mem_data;
      r_rd   <= mem_rd;
      r_src  <= SRC_MEM;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_rd    = r_rd;
  assign out_src   = r_src;

endmodule

// File: tb/tb_wb_output_arbiter.sv
// Randomized and directed checks of wb_output_arbiter against a cycle-level
// reference model of the slot, the arbitration rules and the beat stream.
module tb_wb_output_arbiter;

  localparam int DATA_W     = 32;
  localparam int REG_AW     = 5;
  localparam int STARVE_MAX = 4;

  logic              clk;
  logic              reset;
  logic              alu_valid;
  logic              alu_ready;
  logic [DATA_W-1:0] alu_data;
  logic [REG_AW-1:0] alu_rd;
  logic              mem_valid;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_data;
  logic [REG_AW-1:0] mem_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [REG_AW-1:0] out_rd;
  logic [1:0]        out_src;
  logic [3:0]        starve_cnt;

  wb_output_arbiter #(
    .DATA_W    (DATA_W),
    .REG_AW    (REG_AW),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_data  (alu_data),
    .alu_rd    (alu_rd),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_data  (mem_data),
    .mem_rd    (mem_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_src   (out_src),
    .starve_cnt(starve_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: slot contents, starvation count, expected beat queue
  logic              m_full;
  logic [DATA_W-1:0] m_data;
  logic [REG_AW-1:0] m_rd;
  logic [1:0]        m_src;
  int                m_starve;
  logic [38:0]       exp_q[$];

  task automatic model_reset();
    m_full   = 1'b0;
    m_data   = '0;
    m_rd     = '0;
    m_src    = 2'b00;
    m_starve = 0;
    exp_q.delete();
  endtask

  // Drive one cycle, check outputs against the model, advance the model.
  task automatic step(input logic rst,
                      input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mr, input logic [31:0] md,
                      input logic ordy,
                      output logic a_rdy, output logic m_rdy);
    logic free, a_req, m_req, a_drop, m_drop, exp_a, exp_m;
    int   win; // 0 none, 1 alu, 2 mem
    logic [38:0] beat;
    reset = rst; alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md; out_ready = ordy;
    #1;
    check_eq("out_valid", 64'(out_valid), 64'(m_full));
    check_eq("out_src", 64'(out_src), 64'(m_src));
    check_eq("out_rd", 64'(out_rd), 64'(m_rd));
    check_eq("out_data", 64'(out_data), 64'(m_data));
    check_eq("starve_cnt", 64'(starve_cnt), 64'(m_starve));

    a_drop = av && (ar == 0);
    m_drop = mv && (mr == 0);
    a_req  = av && (ar != 0);
    m_req  = mv && (mr != 0);
    free   = !m_full || ordy;
    win = 0;
    if (!rst && free) begin
      if (a_req && m_req) win = (m_starve >= STARVE_MAX) ? 1 : 2;
      else if (a_req) win = 1;
      else if (m_req) win = 2;
    end
    exp_a = !rst && (a_drop || win == 1);
    exp_m = !rst && (m_drop || win == 2);
    check_eq("alu_ready", 64'(alu_ready), 64'(exp_a));
    check_eq("mem_ready", 64'(mem_ready), 64'(exp_m));
    a_rdy = alu_ready;
    m_rdy = mem_ready;

    if (rst) begin
      model_reset();
    end else begin
      if (m_full && ordy) begin
        check_eq("beat_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          beat = exp_q.pop_front();
          check_eq("beat", {25'd0, out_src, out_rd, out_data}, {25'd0, beat});
        end
      end
      if (a_drop || win == 1) m_starve = 0;
      else if (win == 2 && a_req) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
      if (win == 1) begin
        m_data = ad; m_rd = ar; m_src = 2'b01; m_full = 1'b1;
        exp_q.push_back({2'b01, ar, ad});
      end else if (win == 2) begin
        m_data = md; m_rd = mr; m_src = 2'b10; m_full = 1'b1;
        exp_q.push_back({2'b10, mr, md});
      end else if (m_full && ordy) begin
        m_full = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic ra, rm;
  int   starve_seq[5] = '{1, 2, 3, 4, 0};

  initial begin
    logic        ap, mp;
    logic [4:0]  arr, mrr;
    logic [31:0] adr, mdr;
    logic        rst_r;

    reset = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0; out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    model_reset();

    // reset cycle with requests present: no ready may assert
    step(1, 1, 5'd5, 32'h1, 1, 5'd0, 32'h2, 1, ra, rm);
    check_eq("rst_alu_ready", 64'(ra), 64'd0);
    check_eq("rst_mem_ready", 64'(rm), 64'd0);

    // single ALU request
    step(0, 1, 5'd5, 32'h0000_00AA, 0, 5'd0, 32'h0, 1, ra, rm);
    check_eq("tp1_ready", 64'(ra), 64'd1);
    check_eq("tp1_valid", 64'(out_valid), 64'd1);
    check_eq("tp1_data", 64'(out_data), 64'hAA);
    check_eq("tp1_rd", 64'(out_rd), 64'd5);
    check_eq("tp1_src", 64'(out_src), 64'b01);

    // both valid every cycle: 4 MEM then 1 ALU
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 5'd7, 32'h2222_2222, 1, 5'd3, 32'h1111_1111, 1, ra, rm);
      check_eq("tp2_starve", 64'(starve_cnt), 64'(starve_seq[i % 5]));
      check_eq("tp2_src", 64'(out_src), (i % 5 == 4) ? 64'b01 : 64'b10);
    end

    // backpressure with slot full and a waiting load
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 5'd0, 32'h0, 1, 5'd4, 32'h3333_3333, 0, ra, rm);
      check_eq("tp3_hold_ready", 64'(rm), 64'd0);
      check_eq("tp3_hold_data", 64'(out_data), 64'h2222_2222);
    end
    step(0, 0, 5'd0, 32'h0, 1, 5'd4, 32'h3333_3333, 1, ra, rm);
    check_eq("tp3_release_ready", 64'(rm), 64'd1);
    check_eq("tp3_reload", 64'(out_data), 64'h3333_3333);
    check_eq("tp3_no_bubble", 64'(out_valid), 64'd1);

    // build up starvation, then drop an ALU write to x0 under backpressure
    step(0, 1, 5'd7, 32'h7, 1, 5'd3, 32'h8, 1, ra, rm);
    step(0, 1, 5'd7, 32'h7, 1, 5'd3, 32'h8, 1, ra, rm);
    step(0, 1, 5'd0, 32'h9, 0, 5'd0, 32'h0, 0, ra, rm);
    check_eq("tp4_drop_ready", 64'(ra), 64'd1);
    check_eq("tp4_starve", 64'(starve_cnt), 64'd0);
    check_eq("tp4_hold", 64'(out_data), 64'h8);

    // reset while full
    step(0, 0, 5'd0, 32'h0, 1, 5'd4, 32'hDEAD_BEEF, 1, ra, rm);
    step(1, 1, 5'd2, 32'h1, 1, 5'd6, 32'h2, 1, ra, rm);
    check_eq("tp5_ready", {62'd0, ra, rm}, 64'd0);
    check_eq("tp5_valid", 64'(out_valid), 64'd0);
    check_eq("tp5_data", 64'(out_data), 64'd0);
    check_eq("tp5_src", 64'(out_src), 64'd0);

    // MEM drop and ALU grant together
    step(0, 1, 5'd9, 32'h55, 1, 5'd0, 32'h66, 1, ra, rm);
    check_eq("tp6_ready", {62'd0, ra, rm}, 64'b11);
    check_eq("tp6_src", 64'(out_src), 64'b01);
    check_eq("tp6_rd", 64'(out_rd), 64'd9);
    check_eq("tp6_data", 64'(out_data), 64'h55);

    // randomized traffic with requesters holding until ready
    ap = 0; mp = 0; arr = 0; mrr = 0; adr = 0; mdr = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!ap && $urandom_range(0, 3) != 0) begin
        ap  = 1;
        arr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        adr = $urandom;
      end
      if (!mp && $urandom_range(0, 3) != 0) begin
        mp  = 1;
        mrr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        mdr = $urandom;
      end
      rst_r = ($urandom_range(0, 99) == 0);
      step(rst_r, ap, arr, adr, mp, mrr, mdr, ($urandom_range(0, 3) != 0), ra, rm);
      if (ra) ap = 0;
      if (rm) mp = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_output_arbiter.md
Name: wb_output_arbiter

Overview:
- Shares the single processor-output / register-writeback port between two requesters: ALU results and memory load data.
- Sits between the execute/memory stages and the writeback consumer.
- Replaces the free-running output mux with:
  - valid/ready handshakes,
  - a registered output slot,
  - memory-priority arbitration with an ALU starvation guard.
- Source encoding matches the existing writeback select: 2'b01 = ALU, 2'b10 = memory.

Parameters:
- DATA_W, 32, result data width
- REG_AW, 5, destination register index width
- STARVE_MAX, 4, max consecutive cycles a valid ALU request may lose arbitration before it is forced through (legal range 1..15)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result consumed this cycle
- alu_data  in  DATA_W  ALU result
- alu_rd  in  REG_AW  ALU destination register
- mem_valid  in  1  load data available
- mem_ready  out  1  load data consumed this cycle
- mem_data  in  DATA_W  load data
- mem_rd  in  REG_AW  load destination register
- out_valid  out  1  output slot holds a beat (processor-output flag)
- out_ready  in  1  downstream accepts the beat
- out_data  out  DATA_W  selected result
- out_rd  out  REG_AW  destination of the selected result
- out_src  out  2  source of the current beat: 01 ALU, 10 MEM, 00 none since reset
- starve_cnt  out  4  current ALU starvation count (debug)

Behaviour:
- Reset (sync, active-high, overrides all inputs):
  - out_valid=0, out_data=0, out_rd=0, out_src=00, starve_cnt=0
  - alu_ready=0 and mem_ready=0 during the reset cycle.
- Slot FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
  - slot_free = EMPTY or (FULL and out_ready).
  - FULL with out_ready=0: out_data, out_rd and out_src hold stable.
  - EMPTY: out_data, out_rd and out_src retain the last beat's values; they are not zeroed.
- Zero-destination drop:
  - A request with rd==0 gets ready=1 combinationally in any non-reset cycle, regardless of slot state.
  - It is discarded and produces no output beat.
  - A dropped ALU request clears starve_cnt.
- Arbitration, only among valid requests with rd!=0, only when slot_free:
  - Only one valid: it is granted.
  - Both valid and starve_cnt < STARVE_MAX: MEM granted, starve_cnt increments.
  - Both valid and starve_cnt == STARVE_MAX: ALU granted, starve_cnt clears to 0.
  - ALU granted: starve_cnt clears to 0.
- Grant effects:
  - The granted requester sees ready=1 in the same cycle (combinational from valid, slot state, out_ready, starve_cnt).
  - Next edge loads out_data/out_rd/out_src from the winner and sets out_valid=1.
  - Latency from request to out_valid: 1 cycle.
- Slot not free: no grant, no ready for rd!=0 requests, starve_cnt unchanged.
- Simultaneous drain and grant (FULL, out_ready=1, new grant): the slot reloads and out_valid stays 1. Back-to-back throughput is 1 beat/cycle.
- FULL, out_ready=1, no grant: next state EMPTY.
- starve_cnt saturates at STARVE_MAX and never wraps.
- Reset mid-operation: the held beat is discarded, with no handshake completed in that cycle.
- Inputs are sampled only on cycles where valid=1. Requesters must hold data/rd stable until ready.

Decomposition:
- Shared package holds:
  - source-encoding constants SRC_NONE=2'b00, SRC_ALU=2'b01, SRC_MEM=2'b10 (reused by the control decoder);
  - FSM state constants ST_EMPTY and ST_FULL.
- One natural sub-module, wb_starve_ctr:
  - saturating counter with inc/clr/limit;
  - outputs at_limit.
- Arbitration and slot register stay in the top module.

Test Plan:
- Reset, then a single ALU request alu_valid=1, rd=5, data=0x0000_00AA, out_ready=1 -> alu_ready=1 same cycle; next cycle out_valid=1, out_data=0xAA, out_rd=5, out_src=01.
- Both valid every cycle (mem rd=3, data=0x1111_1111; alu rd=7, data=0x2222_2222), out_ready=1, STARVE_MAX=4:
  - 4 MEM beats, then 1 ALU beat, then repeating;
  - starve_cnt sequence 1,2,3,4,0.
- Downstream backpressure: out_ready=0 for 3 cycles with the slot FULL and mem_valid=1:
  - mem_ready=0 throughout;
  - out_data held at its value;
  - on the out_ready=1 cycle mem_ready=1 and the slot reloads with no bubble.
- alu_rd=0, alu_valid=1 with the slot FULL and out_ready=0 -> alu_ready=1 immediately; no output beat; starve_cnt=0.
- Assert reset while FULL with out_data=0xDEAD_BEEF -> next cycle out_valid=0, out_data=0, out_src=00, starve_cnt=0; no ready asserted during the reset cycle.
- Both valid, mem rd=0, alu rd=9, data=0x55 -> both ready=1 in one cycle; next beat out_src=01, out_rd=9, out_data=0x55.
